// File: rtl/switch_confirm_sync.sv
// Synchronises and debounces 16 DIP switches and the confirm button, then latches a
// switch snapshot on each debounced press with a valid/overrun handshake cleared by rd_ack.
`timescale 1ns/1ps
module switch_confirm_sync #(
    parameter int DB_LIMIT = 1000000,
    parameter int CNT_W    = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw_raw,
    input  logic        btn_raw,
    input  logic        rd_ack,
    output logic [15:0] sw_live,
    output logic [15:0] sw_snap,
    output logic        confirm_pulse,
    output logic        data_valid,
    output logic        overrun
);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DB_LIMIT - 1);

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } btn_state_t;

    logic [15:0]      r_sw_meta;
    logic [15:0]      r_sw_sync;
    logic             r_btn_meta;
    logic             r_btn_sync;

    logic [15:0]      r_sw_cand;
    logic [CNT_W-1:0] r_sw_cnt;
    logic [15:0]      r_sw_live;

    logic             r_btn_cand;
    logic [CNT_W-1:0] r_btn_cnt;
    logic             r_btn_db;

    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic             w_pulse_nxt;
    logic             r_confirm;

    logic [15:0]      r_snap;
    logic             r_valid;
    logic             r_overrun;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
        end else begin
            r_sw_meta  <= sw_raw;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= btn_raw;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Any change of any bit restarts the single shared count for the whole bus.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sw_cand <= '0;
            r_sw_cnt  <= '0;
            r_sw_live <= '0;
        end else if (r_sw_sync != r_sw_cand) begin
            r_sw_cand <= r_sw_sync;
            r_sw_cnt  <= '0;
        end else if (r_sw_cand != r_sw_live) begin
            if (r_sw_cnt == LP_CNT_LAST) begin
                r_sw_live <= r_sw_cand;
                r_sw_cnt  <= '0;
            end else begin
                r_sw_cnt <= r_sw_cnt + CNT_W'(1);
            end
        end else begin
            r_sw_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_btn_cand <= 1'b0;
            r_btn_cnt  <= '0;
            r_btn_db   <= 1'b0;
        end else if (r_btn_sync != r_btn_cand) begin
            r_btn_cand <= r_btn_sync;
            r_btn_cnt  <= '0;
        end else if (r_btn_cand != r_btn_db) begin
            if (r_btn_cnt == LP_CNT_LAST) begin
                r_btn_db  <= r_btn_cand;
                r_btn_cnt <= '0;
            end else begin
                r_btn_cnt <= r_btn_cnt + CNT_W'(1);
            end
        end else begin
            r_btn_cnt <= '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pulse_nxt = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                if (r_btn_db) begin
                    w_state_nxt = ST_PRESSED;
                    w_pulse_nxt = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!r_btn_db) begin
                    w_state_nxt = ST_RELEASED;
                end
            end
            default: w_state_nxt = ST_RELEASED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_RELEASED;
            r_confirm <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_confirm <= w_pulse_nxt;
        end
    end

    // A press coinciding with rd_ack counts the old snapshot as consumed, so no overrun.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_snap    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_confirm) begin
            r_snap  <= r_sw_live;
            r_valid <= 1'b1;
            if (rd_ack) begin
                r_overrun <= 1'b0;
            end else if (r_valid) begin
                r_overrun <= 1'b1;
            end
        end else if (rd_ack) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign sw_live       = r_sw_live;
    assign sw_snap       = r_snap;
    assign confirm_pulse = r_confirm;
    assign data_valid    = r_valid;
    assign overrun       = r_overrun;
endmodule

// File: tb/tb_switch_confirm_sync.sv
// Bench for switch_confirm_sync: directed scenarios plus random pin activity, checked
// against a run-length reference model and a snapshot scoreboard.
`timescale 1ns/1ps
module tb_switch_confirm_sync;
  localparam int DBL = 4;
  localparam int CW  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sw_raw = '0;
  logic        btn_raw = 1'b0;
  logic        rd_ack = 1'b0;
  logic [15:0] sw_live;
  logic [15:0] sw_snap;
  logic        confirm_pulse;
  logic        data_valid;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int dut_pulses = 0;
  int p0;
  bit seen;

  logic [15:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  switch_confirm_sync #(.DB_LIMIT(DBL), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .btn_raw(btn_raw),
    .rd_ack(rd_ack),
    .sw_live(sw_live),
    .sw_snap(sw_snap),
    .confirm_pulse(confirm_pulse),
    .data_valid(data_valid),
    .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a level is accepted once the synchronised input has been seen
  // unchanged on DBL+1 consecutive edges and differs from the accepted level
  logic [16:0] pin_q[$];
  logic [16:0] m_p;
  logic [15:0] m_sw_prev, m_live, m_snap;
  int          m_sw_run, m_b_run;
  logic        m_b_prev, m_db, m_db_last, m_pulse, m_dv, m_ov;

  always @(posedge clk) begin
    if (!rst) begin
      pin_q.delete();
      pin_q.push_back(17'd0);
      pin_q.push_back(17'd0);
      m_sw_prev = '0; m_live = '0; m_snap = '0; m_sw_run = 0; m_b_run = 0;
      m_b_prev = 1'b0; m_db = 1'b0; m_db_last = 1'b0; m_pulse = 1'b0;
      m_dv = 1'b0; m_ov = 1'b0;
    end else begin
      m_p = pin_q.pop_front();
      pin_q.push_back({btn_raw, sw_raw});
      if (m_pulse) begin
        exp_q.push_back(m_live);
        m_snap = m_live;
        if (rd_ack) m_ov = 1'b0;
        else if (m_dv) m_ov = 1'b1;
        m_dv = 1'b1;
      end else if (rd_ack) begin
        m_dv = 1'b0;
        m_ov = 1'b0;
      end
      m_pulse = m_db & ~m_db_last;
      m_db_last = m_db;
      if (m_p[15:0] != m_sw_prev) m_sw_run = 1; else m_sw_run++;
      m_sw_prev = m_p[15:0];
      if (m_sw_run == DBL + 1 && m_p[15:0] != m_live) m_live = m_p[15:0];
      if (m_p[16] != m_b_prev) m_b_run = 1; else m_b_run++;
      m_b_prev = m_p[16];
      if (m_b_run == DBL + 1 && m_p[16] != m_db) m_db = m_p[16];
    end
  end

  // monitor / scoreboard
  logic mon_pend = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (mon_pend) begin
        if (exp_q.size() == 0) begin
          check("spurious_capture", 32'd1, 32'd0);
        end else begin
          check("sb_snap", {16'd0, sw_snap}, {16'd0, exp_q.pop_front()});
        end
      end
      mon_pend = confirm_pulse;
      if (confirm_pulse) dut_pulses++;
      check("live", {16'd0, sw_live}, {16'd0, m_live});
      check("pulse", {31'd0, confirm_pulse}, {31'd0, m_pulse});
      check("valid", {31'd0, data_valid}, {31'd0, m_dv});
      check("overrun", {31'd0, overrun}, {31'd0, m_ov});
    end else begin
      mon_pend = 1'b0;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle_sw(input logic [15:0] v);
    sw_raw = v;
    tick(12);
  endtask

  task automatic press(input int hold);
    btn_raw = 1'b1;
    tick(hold);
    btn_raw = 1'b0;
    tick(12);
  endtask

  task automatic read_ack();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask

  initial begin
    // reset with all pins active
    rst = 1'b0; sw_raw = 16'hFFFF; btn_raw = 1'b1;
    tick(3);
    check("rst_live", {16'd0, sw_live}, 32'd0);
    check("rst_snap", {16'd0, sw_snap}, 32'd0);
    check("rst_pulse", {31'd0, confirm_pulse}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    tick(6);
    check("rel_live_6", {16'd0, sw_live}, 32'd0);
    tick(1);
    check("rel_live_7", {16'd0, sw_live}, 32'h0000FFFF);
    check("rel_no_pulse_yet", {31'd0, confirm_pulse}, 32'd0);
    tick(1);
    check("rel_pulse_8", {31'd0, confirm_pulse}, 32'd1);
    tick(20);
    check("rel_one_pulse", dut_pulses, 32'd1);
    btn_raw = 1'b0;
    tick(12);

    // debounce reject and exact latency
    settle_sw(16'h0000);
    sw_raw = 16'h0008;
    tick(3);
    sw_raw = 16'h0000;
    tick(12);
    check("glitch_reject", {16'd0, sw_live}, 32'd0);
    sw_raw = 16'h00A5;
    tick(6);
    check("lat_before", {16'd0, sw_live}, 32'd0);
    tick(1);
    check("lat_exact", {16'd0, sw_live}, 32'h000000A5);

    // capture and read
    read_ack();
    settle_sw(16'h1234);
    p0 = dut_pulses;
    press(20);
    check("cap_pulses", dut_pulses - p0, 32'd1);
    check("cap_snap", {16'd0, sw_snap}, 32'h00001234);
    check("cap_valid", {31'd0, data_valid}, 32'd1);
    check("cap_no_ovr", {31'd0, overrun}, 32'd0);
    read_ack();
    check("rd_valid", {31'd0, data_valid}, 32'd0);
    check("rd_snap_kept", {16'd0, sw_snap}, 32'h00001234);

    // overrun
    settle_sw(16'h0001);
    press(12);
    settle_sw(16'h0002);
    press(12);
    check("ovr_snap", {16'd0, sw_snap}, 32'h00000002);
    check("ovr_valid", {31'd0, data_valid}, 32'd1);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    read_ack();
    check("ovr_rd_valid", {31'd0, data_valid}, 32'd0);
    check("ovr_rd_flag", {31'd0, overrun}, 32'd0);

    // read in the same cycle as a press, starting from an overrun state
    settle_sw(16'h0003);
    press(12);
    settle_sw(16'h0005);
    press(12);
    check("sim_pre_ovr", {31'd0, overrun}, 32'd1);
    settle_sw(16'h0004);
    btn_raw = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      seen = confirm_pulse;
    end
    check("sim_pulse_wait", {31'd0, seen}, 32'd1);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    check("sim_valid", {31'd0, data_valid}, 32'd1);
    check("sim_ovr_clr", {31'd0, overrun}, 32'd0);
    check("sim_snap", {16'd0, sw_snap}, 32'h00000004);
    btn_raw = 1'b0;
    tick(12);

    // button bounce on press and release
    p0 = dut_pulses;
    for (int i = 0; i < 5; i++) begin
      btn_raw = 1'b1; tick(2);
      btn_raw = 1'b0; tick(2);
    end
    btn_raw = 1'b1;
    tick(10);
    check("bounce_press", dut_pulses - p0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      btn_raw = 1'b0; tick(2);
      btn_raw = 1'b1; tick(2);
    end
    btn_raw = 1'b0;
    tick(12);
    check("bounce_release", dut_pulses - p0, 32'd1);

    // random pin activity with occasional reads
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) sw_raw = 16'($urandom);
      if ($urandom_range(0, 29) == 0) btn_raw = ~btn_raw;
      rd_ack = ($urandom_range(0, 7) == 0);
      tick(1);
    end
    rd_ack = 1'b0;
    btn_raw = 1'b0;
    tick(20);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
